// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a length-prefixed big-endian word stream into write strobes.
// Define IMEM_LOAD_CHECKSUM_EN to append and verify an XOR checksum byte after the data words.
module imem_loader #(
  parameter int PC_WIDTH   = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [PC_WIDTH-1:0] mem_addr,
  output logic [15:0]         mem_wdata,
  output logic                mem_wen,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic                csum_err
);

  localparam logic [16:0] DEPTH_W = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_WRITE,
    S_DONE
`ifdef IMEM_LOAD_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

`ifdef IMEM_LOAD_CHECKSUM_EN
  localparam state_t S_END = S_CSUM;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t                state_q, state_d;
  logic [15:0]           cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  xfer;

  assign xfer     = in_ready & in_valid;
  assign busy     = (state_q != S_IDLE);
  assign cpu_hold = busy;
  assign mem_addr = PC_WIDTH'(addr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    mem_wen  = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_CNT_HI;
      S_CNT_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_CNT_LO;
      end
      S_CNT_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ({cnt_q[15:8], in_data} == 16'd0) ? S_END : S_DAT_HI;
      end
      S_DAT_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_DAT_LO;
      end
      S_DAT_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_WRITE;
      end
      // cnt_q still holds the pre-decrement remaining count here
      S_WRITE: begin
        mem_wen = 1'b1;
        state_d = (cnt_q == 16'd1) ? S_END : S_DAT_HI;
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      S_CSUM: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      mem_wdata <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          addr_q   <= '0;
          overflow <= 1'b0;
        end
        S_CNT_HI: if (xfer) cnt_q[15:8] <= in_data;
        S_CNT_LO: if (xfer) begin
          cnt_q[7:0] <= in_data;
          overflow   <= ({1'b0, cnt_q[15:8], in_data} > DEPTH_W);
        end
        S_DAT_HI: if (xfer) mem_wdata[15:8] <= in_data;
        S_DAT_LO: if (xfer) mem_wdata[7:0]  <= in_data;
        // address wraps modulo depth so oversized loads overwrite from 0
        S_WRITE: begin
          addr_q <= addr_q + 1'b1;
          cnt_q  <= cnt_q - 16'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q   <= '0;
      csum_err <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          csum_q   <= '0;
          csum_err <= 1'b0;
        end
        S_DAT_HI, S_DAT_LO: if (xfer) csum_q <= csum_q ^ in_data;
        S_CSUM: if (xfer) csum_err <= (in_data != csum_q);
        default: ;
      endcase
    end
  end
`else
  assign csum_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: vector table for basic sessions, hand sequences for overflow, gaps, reset, checksum.
module tb_imem_loader;
  localparam int PC_WIDTH   = 8;
  localparam int ADDR_WIDTH = 4;

  logic clk = 1'b0;
  logic rst, start, in_valid;
  logic [7:0] in_data;
  logic in_ready, mem_wen, cpu_hold, busy, done, overflow, csum_err;
  logic [PC_WIDTH-1:0] mem_addr;
  logic [15:0] mem_wdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imem_loader #(.PC_WIDTH(PC_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .overflow(overflow), .csum_err(csum_err)
  );

  // shadow of instruction memory built from observed write strobes
  logic [15:0] shadow [16];
  int wen_cnt = 0;
  always @(negedge clk) if (mem_wen) begin
    shadow[mem_addr[3:0]] = mem_wdata;
    wen_cnt++;
  end

  typedef struct {
    logic        start;
    logic        vld;
    logic [7:0]  data;
    logic        rdy;
    logic        wen;
    logic        hold;
    logic        dn;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic s, input logic v, input logic [7:0] d,
                              input logic r, input logic w, input logic h, input logic dn,
                              input logic [7:0] a, input logic [15:0] wd);
    vec_t e;
    e.start = s; e.vld = v; e.data = d; e.rdy = r; e.wen = w;
    e.hold = h; e.dn = dn; e.addr = a; e.wdata = wd;
    tbl.push_back(e);
  endfunction

  function automatic logic [31:0] pack_out();
    return {2'b00, in_ready, mem_wen, cpu_hold, busy, done, overflow, mem_addr, mem_wdata};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the byte was accepted
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready=%b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_csum(input logic [7:0] b);
`ifdef IMEM_LOAD_CHECKSUM_EN
    send(b);
`else
    in_data = b;
`endif
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(done), 32'd1);
    @(negedge clk);
    chk({nm, "_hold_off"}, 32'(cpu_hold), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    logic [7:0]  acc;
    int          base;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    foreach (shadow[i]) shadow[i] = 16'h0000;

    // 2-word load, then an empty load
    add(1, 0, 8'h00, 0, 0, 0, 0, 8'd0, 16'h0000);
    add(0, 1, 8'h00, 1, 0, 1, 0, 8'd0, 16'h0000);
    add(0, 1, 8'h02, 1, 0, 1, 0, 8'd0, 16'h0000);
    add(0, 1, 8'h92, 1, 0, 1, 0, 8'd0, 16'h0000);
    add(0, 1, 8'h08, 1, 0, 1, 0, 8'd0, 16'h9200);
    add(0, 0, 8'h00, 0, 1, 1, 0, 8'd0, 16'h9208);
    add(0, 1, 8'hA4, 1, 0, 1, 0, 8'd1, 16'h9208);
    add(0, 1, 8'h48, 1, 0, 1, 0, 8'd1, 16'hA408);
    add(0, 0, 8'h00, 0, 1, 1, 0, 8'd1, 16'hA448);
`ifdef IMEM_LOAD_CHECKSUM_EN
    add(0, 1, 8'h76, 1, 0, 1, 0, 8'd2, 16'hA448);
`endif
    add(0, 0, 8'h00, 0, 0, 1, 1, 8'd2, 16'hA448);
    add(0, 0, 8'h00, 0, 0, 0, 0, 8'd2, 16'hA448);
    add(1, 0, 8'h00, 0, 0, 0, 0, 8'd2, 16'hA448);
    add(0, 1, 8'h00, 1, 0, 1, 0, 8'd0, 16'hA448);
    add(0, 1, 8'h00, 1, 0, 1, 0, 8'd0, 16'hA448);
`ifdef IMEM_LOAD_CHECKSUM_EN
    add(0, 1, 8'h00, 1, 0, 1, 0, 8'd0, 16'hA448);
`endif
    add(0, 0, 8'h00, 0, 0, 1, 1, 8'd0, 16'hA448);
    add(0, 0, 8'h00, 0, 0, 0, 0, 8'd0, 16'hA448);

    repeat (2) @(negedge clk);
    chk("reset_outputs", {pack_out()[31:1], csum_err}, 32'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      chk($sformatf("vec%0d", i), pack_out(),
          {2'b00, tbl[i].rdy, tbl[i].wen, tbl[i].hold, tbl[i].hold, tbl[i].dn, 1'b0,
           tbl[i].addr, tbl[i].wdata});
      start    = tbl[i].start;
      in_valid = tbl[i].vld;
      in_data  = tbl[i].data;
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0;
    chk("two_word_shadow", {shadow[0], shadow[1]}, 32'h9208_A448);
    chk("two_load_wen_cnt", 32'(wen_cnt), 32'd2);

    // 17 words into a 16-deep memory
    pulse_start();
    send(8'h00); send(8'h11);
    chk("ovf_set", 32'(overflow), 32'd1);
    acc = 8'h00;
    for (int k = 0; k < 17; k++) begin
      w = 16'h1000 + 16'(k);
      send(w[15:8]); send(w[7:0]);
      acc = acc ^ w[15:8] ^ w[7:0];
    end
    send_csum(acc);
    wait_done("ovf_done");
    chk("ovf_wrap_addr0", 32'(shadow[0]), 32'h1010);
    chk("ovf_addr1", 32'(shadow[1]), 32'h1001);
    chk("ovf_addr15", 32'(shadow[15]), 32'h100F);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_wen_cnt", 32'(wen_cnt), 32'd19);

    // 1-word load with input gaps and a stray start pulse
    pulse_start();
    send(8'h00);
    chk("ovf_cleared", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    send(8'h01);
    repeat (3) @(negedge clk);
    send(8'h12);
    chk("gap_no_write", {30'd0, mem_wen, in_ready}, 32'd1);
    base = wen_cnt;
    pulse_start();
    chk("start_ignored", {30'd0, busy, in_ready}, 32'd3);
    repeat (2) @(negedge clk);
    send(8'h34);
    chk("gap_write", {14'd0, mem_wen, in_ready, mem_addr, mem_wdata}, {14'd0, 1'b1, 1'b0, 8'd0, 16'h1234});
    send_csum(8'h26);
    wait_done("gap_done");
    chk("gap_wen_cnt", 32'(wen_cnt - base), 32'd1);

    // reset after the high byte of the third word
    pulse_start();
    send(8'h00); send(8'h03);
    send(8'hAA); send(8'hAA);
    send(8'hBB); send(8'hBB);
    send(8'hCC);
    base = wen_cnt;
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {pack_out()[31:1], csum_err}, 32'd0);
    repeat (3) @(negedge clk);
    chk("midrst_no_write", 32'(wen_cnt - base), 32'd0);
    chk("midrst_shadow", {shadow[1], shadow[2]}, 32'hBBBB_1002);
    rst = 1'b0;
    @(negedge clk);

`ifdef IMEM_LOAD_CHECKSUM_EN
    pulse_start();
    send(8'h00); send(8'h01); send(8'h5A); send(8'h3C); send(8'h66);
    wait_done("csum_good_done");
    chk("csum_good", 32'(csum_err), 32'd0);
    pulse_start();
    send(8'h00); send(8'h01); send(8'h5A); send(8'h3C); send(8'h67);
    wait_done("csum_bad_done");
    chk("csum_bad", 32'(csum_err), 32'd1);
    pulse_start();
    chk("csum_cleared", 32'(csum_err), 32'd0);
    send(8'h00); send(8'h00); send(8'h00);
    wait_done("csum_empty_done");
`else
    chk("csum_tied", 32'(csum_err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
